caca_niquel_n: RTL and testbench

- Parametrised successor to the fixed 3-counter slot machine.
- NREELS reels, each a mod-(LIMITE+1) counter, run under a spin/stop/evaluate state machine.
- Includes a credit register (coin in, one credit per play, prize on match) and an auto-stop timeout.
- Sits behind SWI/LED/lcd glue in top: reels map onto lcd_a nibbles, credit onto a display register.

---
 rtl/caca_niquel_n.sv | 104 ++++++++++
 tb/tb_caca_niquel_n.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/caca_niquel_n.sv
// Parametrised slot machine: NREELS mod-(LIMITE+1) reels, spin/stop/result FSM, saturating credit and auto-stop timeout.
// All outputs registered; start->spinning takes one edge; no backpressure, every input is sampled each edge.
module caca_niquel_n #(
  parameter int NREELS       = 3,
  parameter int NBITS_COUNT  = 4,
  parameter int INICIO       = 0,
  parameter int LIMITE       = 6,
  parameter int NBITS_CREDIT = 8,
  parameter int PRIZE        = 5,
  parameter int TIMEOUT      = 20
) (
  input  logic                          clk_2,
  input  logic                          reset,
  input  logic                          coin,
  input  logic                          start,
  input  logic [NREELS-1:0]             stop,
  output logic [NREELS*NBITS_COUNT-1:0] reels,
  output logic [NREELS-1:0]             locked,
  output logic [NBITS_CREDIT-1:0]       credit,
  output logic                          spinning,
  output logic                          win,
  output logic [1:0]                    state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SPIN   = 2'd1;
  localparam logic [1:0] RESULT = 2'd2;

  localparam int CNTW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0]        CNT_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [NBITS_COUNT-1:0] INI      = NBITS_COUNT'(INICIO);
  localparam logic [NBITS_COUNT-1:0] LIM      = NBITS_COUNT'(LIMITE);
  localparam logic [32:0]            CMAX     = {{(33-NBITS_CREDIT){1'b0}}, {NBITS_CREDIT{1'b1}}};

  logic [NBITS_COUNT-1:0]  reel_q [NREELS];
  logic [CNTW-1:0]         spin_cnt;
  logic [NREELS-1:0]       locked_nx;
  logic                    play_ok;
  logic                    force_stop;
  logic                    match;
  logic [32:0]             credit_sum;
  logic [NBITS_CREDIT-1:0] credit_nx;

  for (genvar g = 0; g < NREELS; g++) begin : g_reels
    assign reels[g*NBITS_COUNT +: NBITS_COUNT] = reel_q[g];
  end

  assign spinning = (state == SPIN);

  always_comb begin
    match = 1'b1;
    for (int i = 1; i < NREELS; i++) begin
      if (reel_q[i] != reel_q[0]) match = 1'b0;
    end
  end

  // Debit only happens when credit+coin >= 1, so the sum never underflows.
  always_comb begin
    play_ok    = (state == IDLE) && start && ((credit != '0) || coin);
    force_stop = (spin_cnt == CNT_LAST);
    locked_nx  = locked | stop | {NREELS{force_stop}};
    credit_sum = 33'(credit) + 33'(coin)
               + (((state == RESULT) && match) ? 33'(PRIZE) : 33'd0)
               - 33'(play_ok);
    credit_nx  = (credit_sum > CMAX) ? CMAX[NBITS_CREDIT-1:0] : credit_sum[NBITS_CREDIT-1:0];
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      locked   <= '1;
      credit   <= '0;
      win      <= 1'b0;
      spin_cnt <= '0;
      for (int i = 0; i < NREELS; i++) reel_q[i] <= INI;
    end else begin
      credit <= credit_nx;
      case (state)
        IDLE: begin
          if (play_ok) begin
            state    <= SPIN;
            locked   <= '0;
            spin_cnt <= '0;
            win      <= 1'b0;
          end
        end
        SPIN: begin
          locked   <= locked_nx;
          spin_cnt <= spin_cnt + 1'b1;
          for (int i = 0; i < NREELS; i++) begin
            if (!locked_nx[i]) reel_q[i] <= (reel_q[i] == LIM) ? INI : reel_q[i] + 1'b1;
          end
          if (&locked_nx) state <= RESULT;
        end
        RESULT: begin
          win   <= match;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_caca_niquel_n.sv
// Directed bench for caca_niquel_n; play outcomes go through a scoreboard checked on RESULT->IDLE.
module tb_caca_niquel_n;

  logic        clk_2 = 1'b0;
  logic        reset;
  logic        coin;
  logic        start;
  logic [2:0]  stop;
  logic [11:0] reels;
  logic [2:0]  locked;
  logic [7:0]  credit;
  logic        spinning;
  logic        win;
  logic [1:0]  state;

  typedef struct packed {
    logic [11:0] r;
    logic        w;
    logic [7:0]  c;
  } play_t;

  play_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  logic [1:0] prev_st = 2'd0;

  always #5 clk_2 = ~clk_2;

  caca_niquel_n dut (
    .clk_2   (clk_2),
    .reset   (reset),
    .coin    (coin),
    .start   (start),
    .stop    (stop),
    .reels   (reels),
    .locked  (locked),
    .credit  (credit),
    .spinning(spinning),
    .win     (win),
    .state   (state)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rv(input int a0, input int a1, input int a2);
    return (a2 << 8) | (a1 << 4) | a0;
  endfunction

  task automatic expect_play(input int r, input int w, input int c);
    play_t p;
    p.r = 12'(r);
    p.w = 1'(w);
    p.c = 8'(c);
    exp_q.push_back(p);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk_2);
  endtask

  // Scoreboard monitor: a finished play is visible on the RESULT->IDLE transition.
  always @(negedge clk_2) begin
    play_t e;
    if (prev_st == 2'd2 && state == 2'd0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL play_unexpected: got reels 0x%0h with no expected play", reels);
      end else begin
        e = exp_q.pop_front();
        chk("play_reels", 32'(reels), 32'(e.r));
        chk("play_win", 32'(win), 32'(e.w));
        chk("play_credit", 32'(credit), 32'(e.c));
      end
    end
    prev_st = state;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; coin = 1'b0; start = 1'b0; stop = 3'b000;
    step(2);
    chk("rst_state", 32'(state), 0);
    chk("rst_reels", 32'(reels), 0);
    chk("rst_locked", 32'(locked), 7);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_win", 32'(win), 0);
    chk("rst_spinning", 32'(spinning), 0);
    reset = 1'b1;
    step();

    // Coins, then a play stopped with all reels at 3
    coin = 1'b1; step(2); coin = 1'b0;
    chk("coin_credit", 32'(credit), 2);
    start = 1'b1; step(); start = 1'b0;
    chk("start_state", 32'(state), 1);
    chk("start_credit", 32'(credit), 1);
    chk("start_locked", 32'(locked), 0);
    chk("start_spinning", 32'(spinning), 1);
    chk("start_reels", 32'(reels), rv(0, 0, 0));
    step(); chk("adv1", 32'(reels), rv(1, 1, 1));
    step(); chk("adv2", 32'(reels), rv(2, 2, 2));
    step(); chk("adv3", 32'(reels), rv(3, 3, 3));
    expect_play(rv(3, 3, 3), 1, 6);
    stop = 3'b111; step(); stop = 3'b000;
    chk("stop_all_state", 32'(state), 2);
    chk("stop_all_locked", 32'(locked), 7);
    chk("stop_all_reels", 32'(reels), rv(3, 3, 3));
    start = 1'b1; step(); start = 1'b0;
    chk("result_start_ignored", 32'(state), 0);
    chk("win_held", 32'(win), 1);

    // Staggered stops with wrap
    start = 1'b1; step(); start = 1'b0;
    chk("p2_credit", 32'(credit), 5);
    step(3); chk("wrap_pre", 32'(reels), rv(6, 6, 6));
    step();  chk("wrap", 32'(reels), rv(0, 0, 0));
    step(2); chk("p2_at2", 32'(reels), rv(2, 2, 2));
    expect_play(rv(2, 4, 3), 0, 5);
    stop = 3'b001; step();
    stop = 3'b100; step();
    stop = 3'b010; step();
    stop = 3'b000;
    chk("stagger_state", 32'(state), 2);
    chk("stagger_reels", 32'(reels), rv(2, 4, 3));
    step();

    // Asynchronous reset between edges, mid-SPIN
    start = 1'b1; step(); start = 1'b0;
    chk("p3_credit", 32'(credit), 4);
    step(2);
    #2 reset = 1'b0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_reels", 32'(reels), 0);
    chk("arst_credit", 32'(credit), 0);
    chk("arst_locked", 32'(locked), 7);
    chk("arst_win", 32'(win), 0);
    step(); reset = 1'b1;

    // No credit, no coin: start ignored; with same-edge coin: accepted
    start = 1'b1; step();
    chk("nocredit_state", 32'(state), 0);
    chk("nocredit_credit", 32'(credit), 0);
    coin = 1'b1; step(); start = 1'b0; coin = 1'b0;
    chk("coinstart_state", 32'(state), 1);
    chk("coinstart_credit", 32'(credit), 0);

    // Timeout with synchronous start
    step(19);
    chk("to_pre_locked", 32'(locked), 0);
    chk("to_pre_state", 32'(state), 1);
    chk("to_pre_reels", 32'(reels), rv(5, 5, 5));
    expect_play(rv(5, 5, 5), 1, 5);
    step();
    chk("to_locked", 32'(locked), 7);
    chk("to_state", 32'(state), 2);
    step();

    // Timeout with reel 0 stopped early
    start = 1'b1; step(); start = 1'b0;
    chk("p5_credit", 32'(credit), 4);
    stop = 3'b001; step(); stop = 3'b000;
    chk("early_locked", 32'(locked), 1);
    chk("early_reels", 32'(reels), rv(5, 6, 6));
    step(18);
    chk("to2_pre_locked", 32'(locked), 1);
    chk("to2_pre_state", 32'(state), 1);
    expect_play(rv(5, 3, 3), 0, 4);
    step();
    chk("to2_locked", 32'(locked), 7);
    step();

    // Saturation: coin at max, then 254 + coin + prize in RESULT
    coin = 1'b1; step(252); coin = 1'b0;
    chk("sat_coin", 32'(credit), 255);
    start = 1'b1; step(); start = 1'b0;
    chk("p6_credit", 32'(credit), 254);
    stop = 3'b110; step(); stop = 3'b000;
    step(4);
    chk("p6_align", 32'(reels), rv(3, 3, 3));
    chk("p6_locked", 32'(locked), 6);
    stop = 3'b001; step(); stop = 3'b000;
    chk("p6_state", 32'(state), 2);
    coin = 1'b1;
    expect_play(rv(3, 3, 3), 1, 255);
    step(); coin = 1'b0;
    step(2);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
